// File: rtl/sha256_block_ctrl_pkg.sv
// Shared definitions for the SHA-256 block controller: word/round sizes,
// FSM state encoding and the round-constant table K[0..63].
package sha256_block_ctrl_pkg;

   localparam int WORD_WIDTH    = 32;
   localparam int NUM_MSG_WORDS = 16;
   localparam int NUM_ROUNDS    = 64;
   localparam int CNT_W         = 6;
   localparam int ROUND_W       = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXPAND = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FINAL  = 3'd5
   } state_e;

   localparam logic [WORD_WIDTH-1:0] K_TABLE [NUM_ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [WORD_WIDTH-1:0] sha256_k(input logic [ROUND_W-1:0] idx);
      return K_TABLE[idx];
   endfunction

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// Bundle of the controller's handshake and strobe signals.
//   slave  : controller side (message input, scheduler/compressor drive)
//   master : padder / scheduler / compressor side
//   start, abort           : block control
//   msg_valid/msg_word/msg_ready : message word handshake, W0 first
//   sch_en/sch_load/sch_msg_in   : scheduler drive
//   cmp_init/cmp_en/round_t/k_t/cmp_final : compressor drive
//   busy, done             : status
interface sha256_block_ctrl_if;
   import sha256_block_ctrl_pkg::*;

   logic                  start;
   logic                  abort;
   logic                  msg_valid;
   logic [WORD_WIDTH-1:0] msg_word;
   logic                  msg_ready;
   logic                  sch_en;
   logic                  sch_load;
   logic [WORD_WIDTH-1:0] sch_msg_in;
   logic                  cmp_init;
   logic                  cmp_en;
   logic [ROUND_W-1:0]    round_t;
   logic [WORD_WIDTH-1:0] k_t;
   logic                  cmp_final;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, abort, msg_valid, msg_word,
      output msg_ready, sch_en, sch_load, sch_msg_in,
      output cmp_init, cmp_en, round_t, k_t, cmp_final, busy, done
   );

   modport master (
      output start, abort, msg_valid, msg_word,
      input  msg_ready, sch_en, sch_load, sch_msg_in,
      input  cmp_init, cmp_en, round_t, k_t, cmp_final, busy, done
   );

endinterface

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[round_i].
//   round_i : round index 0..63
//   k_o     : K constant for that round
module sha256_k_rom
   import sha256_block_ctrl_pkg::*;
(
   input  logic [ROUND_W-1:0]    round_i,
   output logic [WORD_WIDTH-1:0] k_o
);

   assign k_o = sha256_k(round_i);

endmodule

// File: rtl/sha256_block_ctrl.sv
// Sequences one 512-bit block through the SHA-256 scheduler and compressor:
// loads 16 message words, runs 48 expansion cycles, and issues round
// enables one cycle behind the scheduler because the scheduler output is
// registered. Brackets the block with cmp_init and cmp_final.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sha256_block_ctrl_if.slave (handshake, scheduler and compressor drive)
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | compressor loads a..h from hash state, word counter cleared
// LOAD   | accepting W0..W15, scheduler in load mode
// EXPAND | scheduler expands W16..W63
// DRAIN  | last round (63) executes from the registered cmp_en
// FINAL  | compressor adds working vars into hash state, done pulse
module sha256_block_ctrl
   import sha256_block_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   sha256_block_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_MSG   = CNT_W'(NUM_MSG_WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      w_cnt_q, w_cnt_d;
   logic                  cmp_en_q, cmp_en_d;
   logic [ROUND_W-1:0]    round_q, round_d;
   logic                  sch_en;
   logic                  sch_load;
   logic                  msg_ready;
   logic [WORD_WIDTH-1:0] sch_msg_in;
   logic                  abort_hit;
   logic [WORD_WIDTH-1:0] k_rom;

   always_comb begin
      state_d    = state_q;
      w_cnt_d    = w_cnt_q;
      sch_en     = 1'b0;
      sch_load   = 1'b0;
      msg_ready  = 1'b0;
      sch_msg_in = '0;
      abort_hit  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_INIT;
         end
         ST_INIT: begin
            w_cnt_d = '0;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            msg_ready  = 1'b1;
            sch_load   = 1'b1;
            sch_en     = bus.msg_valid;
            sch_msg_in = bus.msg_word;
            if (bus.msg_valid) begin
               w_cnt_d = w_cnt_q + 1'b1;
               if (w_cnt_q == LAST_MSG) state_d = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            sch_en = 1'b1;
            // Hold at 63 on exit so the counter never wraps.
            if (w_cnt_q == LAST_ROUND) state_d = ST_DRAIN;
            else                       w_cnt_d = w_cnt_q + 1'b1;
         end
         ST_DRAIN: begin
            state_d = ST_FINAL;
         end
         ST_FINAL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides every transition, including the round pipeline.
      if (bus.abort && (state_q != ST_IDLE)) begin
         abort_hit = 1'b1;
         state_d   = ST_IDLE;
      end

      // Round t runs the cycle after scheduler word t is issued; a stalled
      // cycle issues nothing, so rounds are never skipped or repeated.
      cmp_en_d = sch_en && !abort_hit;
      round_d  = sch_en ? w_cnt_q : round_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         w_cnt_q  <= '0;
         cmp_en_q <= 1'b0;
         round_q  <= '0;
      end else begin
         state_q  <= state_d;
         w_cnt_q  <= w_cnt_d;
         cmp_en_q <= cmp_en_d;
         round_q  <= round_d;
      end
   end

   sha256_k_rom u_k_rom (
      .round_i (round_q),
      .k_o     (k_rom)
   );

   assign bus.msg_ready  = msg_ready;
   assign bus.sch_en     = sch_en;
   assign bus.sch_load   = sch_load;
   assign bus.sch_msg_in = sch_msg_in;
   assign bus.cmp_init   = (state_q == ST_INIT);
   assign bus.cmp_en     = cmp_en_q;
   assign bus.round_t    = round_q;
   // K is only meaningful alongside cmp_en; zero otherwise so idle/reset
   // leaves every output at 0.
   assign bus.k_t        = cmp_en_q ? k_rom : '0;
   assign bus.cmp_final  = (state_q == ST_FINAL);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_FINAL);

endmodule

// File: tb/tb_sha256_block_ctrl.sv
module tb_sha256_block_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_block_ctrl_if ifc ();

   sha256_block_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] EXP_ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                       32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

   logic [31:0] K_TB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [31:0] msg [16];

   // ---------------- reference scheduler + compressor ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction
   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
      return r;
   endfunction

   logic [31:0]  win [16];
   logic [31:0]  w_q;
   logic [31:0]  w_next;
   logic [255:0] hs;
   logic [255:0] wv;
   logic         h_reset = 1'b1;

   assign w_next = ifc.sch_load ? ifc.sch_msg_in
                                : (ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0]);

   always @(posedge clk) begin
      if (ifc.sch_en) begin
         for (int i = 0; i < 15; i++) win[i] <= win[i+1];
         win[15] <= w_next;
         w_q     <= w_next;
      end
      if (h_reset)            hs <= IV;
      else if (ifc.cmp_final) hs <= add8(hs, wv);
      if (ifc.cmp_init)       wv <= hs;
      else if (ifc.cmp_en)    wv <= sha_round(wv, ifc.k_t, w_q);
   end

   // ---------------- event monitor ----------------
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int base = 0;
   int run_id = 0;
   int seen_id = 0;
   bit mon_en = 1'b0;
   int rel, done_cnt, done_cyc, cmp_cnt, first_cmp, last_cmp;
   int round_err, k_err, init_cnt, final_cnt, exp_round;
   logic [31:0] k_at0, k_at63;

   always @(negedge clk) begin
      if (run_id != seen_id) begin
         seen_id = run_id;
         done_cnt = 0; done_cyc = -1; cmp_cnt = 0; first_cmp = -1; last_cmp = -1;
         round_err = 0; k_err = 0; init_cnt = 0; final_cnt = 0; exp_round = 0;
         k_at0 = '0; k_at63 = '0;
      end
      if (mon_en) begin
         rel = cyc_cnt - base;
         if (ifc.cmp_en) begin
            if (ifc.round_t !== 6'(exp_round)) round_err++;
            if (ifc.k_t !== K_TB[ifc.round_t]) k_err++;
            if (ifc.round_t == 6'd0)  k_at0  = ifc.k_t;
            if (ifc.round_t == 6'd63) k_at63 = ifc.k_t;
            exp_round++;
            cmp_cnt++;
            if (first_cmp < 0) first_cmp = rel;
            last_cmp = rel;
         end
         if (ifc.done)      begin done_cnt++; done_cyc = rel; end
         if (ifc.cmp_init)  init_cnt++;
         if (ifc.cmp_final) final_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Start a block at the next edge (edge 0 -> cycle 1 = INIT), then feed
   // W0..W15, optionally stalling stall_len cycles after words 4 and 11.
   task automatic load_words(input int stall_len);
      int n;
      h_reset = 1'b1;
      @(posedge clk); #1;
      h_reset = 1'b0;
      run_id++;
      @(negedge clk);
      mon_en = 1'b1;
      ifc.start = 1'b1;
      ifc.msg_valid = 1'b1;
      ifc.msg_word = msg[0];
      @(posedge clk); #1;
      ifc.start = 1'b0;
      base = cyc_cnt - 1;
      for (int i = 0; i < 16; i++) begin
         ifc.msg_valid = 1'b1;
         ifc.msg_word = msg[i];
         n = 0;
         @(negedge clk);
         while (!ifc.msg_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!ifc.msg_ready) begin
            checks++; errors++;
            $display("FAIL load_timeout: msg_ready=%0b for word %0d, expected 1", ifc.msg_ready, i);
         end
         @(posedge clk); #1;
         if ((i == 4 || i == 11) && stall_len > 0) begin
            ifc.msg_valid = 1'b0;
            repeat (stall_len) begin @(posedge clk); #1; end
         end
      end
      ifc.msg_valid = 1'b0;
      ifc.msg_word = '0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (ifc.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (ifc.busy) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy=%0b, expected 0", ifc.busy);
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #12;
      checks++; if (ifc.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", ifc.busy); end
      checks++; if (ifc.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b expected 0", ifc.done); end
      checks++; if (ifc.msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready: got %0b expected 0", ifc.msg_ready); end
      checks++; if (ifc.sch_en !== 1'b0)    begin errors++; $display("FAIL reset_sch_en: got %0b expected 0", ifc.sch_en); end
      checks++; if (ifc.cmp_en !== 1'b0)    begin errors++; $display("FAIL reset_cmp_en: got %0b expected 0", ifc.cmp_en); end
      checks++; if (ifc.round_t !== 6'd0)   begin errors++; $display("FAIL reset_round_t: got %0d expected 0", ifc.round_t); end
      checks++; if (ifc.k_t !== 32'd0)      begin errors++; $display("FAIL reset_k_t: got %h expected 0", ifc.k_t); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abc();
      load_words(0);
      wait_idle();
      checks++; if (done_cnt !== 1)   begin errors++; $display("FAIL abc_done_count: got %0d expected 1", done_cnt); end
      checks++; if (done_cyc !== 67)  begin errors++; $display("FAIL abc_done_cycle: got %0d expected 67", done_cyc); end
      checks++; if (cmp_cnt !== 64)   begin errors++; $display("FAIL abc_cmp_en_count: got %0d expected 64", cmp_cnt); end
      checks++; if (first_cmp !== 3)  begin errors++; $display("FAIL abc_cmp_en_first: got %0d expected 3", first_cmp); end
      checks++; if (last_cmp !== 66)  begin errors++; $display("FAIL abc_cmp_en_last: got %0d expected 66", last_cmp); end
      checks++; if (round_err !== 0)  begin errors++; $display("FAIL abc_round_seq: got %0d bad rounds expected 0", round_err); end
      checks++; if (init_cnt !== 1)   begin errors++; $display("FAIL abc_init_count: got %0d expected 1", init_cnt); end
      checks++; if (final_cnt !== 1)  begin errors++; $display("FAIL abc_final_count: got %0d expected 1", final_cnt); end
      checks++; if (hs !== EXP_ABC)   begin errors++; $display("FAIL abc_hash: got %h expected %h", hs, EXP_ABC); end
   endtask

   task automatic test_stall();
      load_words(3);
      wait_idle();
      checks++; if (done_cyc !== 73)  begin errors++; $display("FAIL stall_done_cycle: got %0d expected 73", done_cyc); end
      checks++; if (done_cnt !== 1)   begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
      checks++; if (cmp_cnt !== 64)   begin errors++; $display("FAIL stall_cmp_en_count: got %0d expected 64", cmp_cnt); end
      checks++; if (round_err !== 0)  begin errors++; $display("FAIL stall_round_seq: got %0d bad rounds expected 0", round_err); end
      checks++; if (hs !== EXP_ABC)   begin errors++; $display("FAIL stall_hash: got %h expected %h", hs, EXP_ABC); end
   endtask

   task automatic test_k_rom();
      load_words(0);
      wait_idle();
      checks++; if (k_at0 !== 32'h428a2f98)  begin errors++; $display("FAIL k_round0: got %h expected 428a2f98", k_at0); end
      checks++; if (k_at63 !== 32'hc67178f2) begin errors++; $display("FAIL k_round63: got %h expected c67178f2", k_at63); end
      checks++; if (k_err !== 0)             begin errors++; $display("FAIL k_table: got %0d bad K values expected 0", k_err); end
   endtask

   task automatic test_start_in_expand();
      load_words(0);
      repeat (10) begin @(posedge clk); #1; end
      checks++; if (ifc.sch_load !== 1'b0 || ifc.sch_en !== 1'b1) begin
         errors++; $display("FAIL start_pulse_in_expand: sch_en=%0b sch_load=%0b expected 1/0", ifc.sch_en, ifc.sch_load);
      end
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      wait_idle();
      checks++; if (done_cyc !== 67) begin errors++; $display("FAIL start_ignored_done_cycle: got %0d expected 67", done_cyc); end
      checks++; if (init_cnt !== 1)  begin errors++; $display("FAIL start_ignored_init_count: got %0d expected 1", init_cnt); end
      checks++; if (cmp_cnt !== 64)  begin errors++; $display("FAIL start_ignored_cmp_count: got %0d expected 64", cmp_cnt); end
      checks++; if (hs !== EXP_ABC)  begin errors++; $display("FAIL start_ignored_hash: got %h expected %h", hs, EXP_ABC); end
   endtask

   task automatic test_abort();
      int n = 0;
      load_words(0);
      @(negedge clk);
      while (!(ifc.cmp_en && ifc.round_t == 6'd30) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (ifc.round_t !== 6'd30 || ifc.cmp_en !== 1'b1) begin
         errors++; $display("FAIL abort_reach_round30: round_t=%0d cmp_en=%0b expected 30/1", ifc.round_t, ifc.cmp_en);
      end
      ifc.abort = 1'b1;
      @(posedge clk); #1;
      ifc.abort = 1'b0;
      checks++; if (ifc.busy !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %0b expected 0", ifc.busy); end
      checks++; if (ifc.cmp_en !== 1'b0) begin errors++; $display("FAIL abort_cmp_en: got %0b expected 0", ifc.cmp_en); end
      repeat (70) @(negedge clk);
      checks++; if (done_cnt !== 0)  begin errors++; $display("FAIL abort_done_count: got %0d expected 0", done_cnt); end
      checks++; if (final_cnt !== 0) begin errors++; $display("FAIL abort_final_count: got %0d expected 0", final_cnt); end
      checks++; if (hs !== IV)       begin errors++; $display("FAIL abort_hash_untouched: got %h expected %h", hs, IV); end
      load_words(0);
      wait_idle();
      checks++; if (done_cyc !== 67) begin errors++; $display("FAIL abort_recover_done_cycle: got %0d expected 67", done_cyc); end
      checks++; if (hs !== EXP_ABC)  begin errors++; $display("FAIL abort_recover_hash: got %h expected %h", hs, EXP_ABC); end
   endtask

   task automatic test_async_reset();
      h_reset = 1'b1;
      @(posedge clk); #1;
      h_reset = 1'b0;
      run_id++;
      @(negedge clk);
      mon_en = 1'b1;
      ifc.start = 1'b1;
      ifc.msg_valid = 1'b1;
      ifc.msg_word = msg[0];
      @(posedge clk); #1;
      ifc.start = 1'b0;
      base = cyc_cnt - 1;
      repeat (4) begin @(posedge clk); #1; end
      checks++; if (ifc.busy !== 1'b1 || ifc.msg_ready !== 1'b1) begin
         errors++; $display("FAIL rst_in_load: busy=%0b msg_ready=%0b expected 1/1", ifc.busy, ifc.msg_ready);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({ifc.busy, ifc.done, ifc.msg_ready, ifc.sch_en, ifc.sch_load, ifc.cmp_init, ifc.cmp_en, ifc.cmp_final} !== 8'd0) begin
         errors++; $display("FAIL rst_async_flags: got %b expected 00000000",
                            {ifc.busy, ifc.done, ifc.msg_ready, ifc.sch_en, ifc.sch_load, ifc.cmp_init, ifc.cmp_en, ifc.cmp_final});
      end
      checks++; if (ifc.sch_msg_in !== 32'd0 || ifc.k_t !== 32'd0 || ifc.round_t !== 6'd0) begin
         errors++; $display("FAIL rst_async_buses: sch_msg_in=%h k_t=%h round_t=%0d expected 0", ifc.sch_msg_in, ifc.k_t, ifc.round_t);
      end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt !== 0 || final_cnt !== 0) begin
         errors++; $display("FAIL rst_no_finish: done=%0d final=%0d expected 0/0", done_cnt, final_cnt);
      end
      ifc.msg_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      load_words(0);
      wait_idle();
      checks++; if (done_cyc !== 67) begin errors++; $display("FAIL rst_restart_done_cycle: got %0d expected 67", done_cyc); end
      checks++; if (init_cnt !== 1)  begin errors++; $display("FAIL rst_restart_init_count: got %0d expected 1", init_cnt); end
      checks++; if (hs !== EXP_ABC)  begin errors++; $display("FAIL rst_restart_hash: got %h expected %h", hs, EXP_ABC); end
   endtask

   initial begin
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      ifc.msg_valid = 1'b0;
      ifc.msg_word = '0;
      for (int i = 0; i < 16; i++) msg[i] = '0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      test_reset();
      test_abc();
      test_stall();
      test_k_rom();
      test_start_in_expand();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
Sequencing controller for one 512-bit block through the SHA-256 message scheduler and compressor.
- Accepts 16 message words over a valid/ready handshake and drives the scheduler's en/load pins.
- Runs the 48 expansion cycles and issues aligned round enables, round index and K constant to the compressor.
- Brackets the block with compressor init and final-add strobes.
- Sits inside sha256_update, between the padder output and the scheduler/compressor pair.

Parameters:
WORD_WIDTH, 32, message/schedule word width
NUM_MSG_WORDS, 16, words loaded per block
NUM_ROUNDS, 64, compression rounds per block

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a block; sampled only in IDLE
abort  input  1  synchronous abort; return to IDLE next edge
msg_valid  input  1  msg_word valid
msg_word  input  WORD_WIDTH  preprocessed message word, W0 first
msg_ready  output  1  controller accepts msg_word this cycle
sch_en  output  1  scheduler enable
sch_load  output  1  scheduler load select (1 = msg, 0 = expand)
sch_msg_in  output  WORD_WIDTH  word to scheduler msg input (msg_word pass-through)
cmp_init  output  1  compressor loads working vars a..h from hash state
cmp_en  output  1  compressor performs one round using the scheduler's sch_msg
round_t  output  6  round index of current cmp_en cycle
k_t  output  WORD_WIDTH  K[round_t]
cmp_final  output  1  compressor adds working vars into hash state
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, block complete

Behaviour:
- States: IDLE, INIT, LOAD, EXPAND, DRAIN, FINAL. Internal word counter w_cnt is 6 bits.
- Reset (rst_n low, async): state=IDLE, w_cnt=0, cmp_en=0, round_t=0. All outputs are 0.
- IDLE: msg_ready=0. start=1 moves to INIT. Any start outside IDLE is ignored.
- INIT (1 cycle): cmp_init=1. w_cnt clears to 0. Next state is LOAD.
- LOAD:
  - msg_ready=1, sch_load=1, sch_en=msg_valid, sch_msg_in=msg_word.
  - Each accepted word increments w_cnt. When word 15 is accepted, next state is EXPAND.
  - msg_valid low stalls the controller: scheduler holds, no round is issued.
- EXPAND: sch_en=1, sch_load=0, msg_ready=0. w_cnt increments each cycle. When w_cnt=63 is issued, next state is DRAIN.
- DRAIN (1 cycle): sch_en=0. The registered cmp_en covers round 63.
- FINAL (1 cycle): cmp_final=1, done=1. Next state is IDLE.
- Round alignment: the scheduler output is registered.
  - cmp_en and round_t are registers, loaded each edge with sch_en and w_cnt.
  - So round t executes exactly one cycle after scheduler word t is issued.
  - Stalls never duplicate or skip a round.
- k_t is combinational from round_t.
- sch_en, sch_load, msg_ready and sch_msg_in are combinational from state and msg_valid.
- busy and done are decoded from state.
- Latency with msg_valid held high: start sampled at edge 0.
  - INIT is cycle 1, LOAD is cycles 2–17, EXPAND is cycles 18–65, DRAIN is cycle 66.
  - FINAL/done is cycle 67.
  - cmp_en is high in cycles 3–66 (64 cycles).
- abort=1 in any non-IDLE state moves to IDLE at the next edge and clears cmp_en. done is not pulsed. abort has priority over all transitions.
- Reset mid-block: immediate IDLE. No cmp_final, no done.
- Counter wrap: w_cnt never wraps. The EXPAND exit compares w_cnt==NUM_ROUNDS-1.

Decomposition:
- Shared package/header (sha256.vh): WORD_WIDTH, MSG_BLOCK_SIZE, NUM_ROUNDS, state encodings, and the K constant function/table.
- Natural sub-module: sha256_k_rom, a combinational 64-entry K lookup indexed by round_t, reusable by the compressor.
- The FSM and counters live in sha256_block_ctrl.

Test Plan:
1. Reset then start, msg_valid held high, words 0x61626380, then 14×0, then 0x00000018 ("abc").
   - done pulses exactly once, in cycle 67.
   - cmp_en is high for 64 consecutive cycles, round_t runs 0..63.
   - Final hash matches ba7816bf…f20015ad.
2. Same message with msg_valid deasserted for 3 cycles after words 4 and 11.
   - done is delayed by exactly 6 cycles.
   - round_t sequence has no gaps or repeats; hash is unchanged from scenario 1.
3. Check k_t against round_t.
   - k_t=0x428a2f98 at round_t=0.
   - k_t=0xc67178f2 at round_t=63.
   - k_t is sampled whenever cmp_en=1.
4. Pulse start during EXPAND.
   - State, w_cnt and done timing are unaffected; no second cmp_init.
5. Assert abort in EXPAND at round 30.
   - Next cycle busy=0 and cmp_en=0; no cmp_final, no done.
   - A subsequent "abc" block still hashes correctly.
6. Drop rst_n asynchronously mid-LOAD, between clock edges.
   - All outputs go to 0 without waiting for a clock edge.
   - After release, start restarts cleanly from INIT.
